fifo_wr_arbiter: RTL and testbench

//  Shares the write port of one fifo between N_REQ requesters with round-robin arbitration.

---
 rtl/fifo_wr_arbiter.sv | 97 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between N_REQ requesters.
// A grant lasts for up to MAX_BURST writes; data and strobe are combinational from the owner.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 4,
    localparam int ID_W      = (N_REQ > 2) ? $clog2(N_REQ) : 1,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              ack,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    input  logic                          fifo_full,
    output logic [ID_W-1:0]               gnt_id,
    output logic                          busy
);

    typedef enum logic {IDLE, BURST} state_e;

    state_e           state_q;
    logic [ID_W-1:0]  owner_q;
    logic [CNT_W-1:0] cnt_q;

    logic                  own_req;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] words [N_REQ];

    // First requester above the current owner, wrapping; the owner itself comes last.
    function automatic logic [ID_W-1:0] pick(input logic [N_REQ-1:0] v,
                                             input logic [ID_W-1:0]  from);
        logic [ID_W-1:0] res;
        logic            found;
        int              idx;
        res   = from;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(from) + k) % N_REQ;
            if (!found && |(v & (N_REQ'(1) << idx))) begin
                res   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign own_req   = req[owner_q];
    assign xfer      = (state_q == BURST) && own_req && !fifo_full;
    assign fifo_wr   = xfer;
    assign fifo_data = words[owner_q];
    assign ack       = xfer ? (N_REQ'(1) << owner_q) : '0;
    assign gnt_id    = owner_q;
    assign busy      = (state_q == BURST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= ID_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= BURST;
                        owner_q <= pick(req, owner_q);
                        cnt_q   <= '0;
                    end
                end
                BURST: begin
                    // A full fifo with the owner still requesting freezes the grant.
                    if (!(own_req && fifo_full)) begin
                        if (xfer && cnt_q < CNT_W'(MAX_BURST - 1)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end else if (|req) begin
                            // owner bit is already clear here if it dropped its request
                            owner_q <= pick(req, owner_q);
                            cnt_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: a grant-level reference model predicts each fifo
// write (requester, word, cycle) into a queue that a negedge monitor checks against the DUT.
module tb_fifo_wr_arbiter;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  ack;
    logic          fifo_wr;
    logic [DW-1:0] fifo_data;
    logic          fifo_full;
    logic [1:0]    gnt_id;
    logic          busy;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .fifo_wr(fifo_wr), .fifo_data(fifo_data), .fifo_full(fifo_full),
        .gnt_id(gnt_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] cur [N];
    bit   [N-1:0]  want;
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            rst_edge = 1'b0;
    bit            exp_busy = 1'b0;
    int            exp_gnt = N - 1;
    int            mode = 1;
    bit            rst_next = 1'b1;

    // reference model: grant owner, writes done in this grant, granted or not
    bit            m_busy = 1'b0;
    int            m_owner = N - 1;
    int            m_writes = 0;

    task automatic chk(input bit ok, input string name, input int act, input int expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    function automatic int next_owner(input bit [N-1:0] v, input int from);
        for (int k = 1; k <= N; k++) begin
            if (v[2'((from + k) % N)]) return (from + k) % N;
        end
        return from;
    endfunction

    task automatic drive_cycle();
        bit [N-1:0] r;
        bit         full;
        bit         wr;
        @(posedge clk);
        cyc++;
        rst_edge = rst;
        #1;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       want[i] = (i == 1);
                1:       want[i] = 1'b1;
                2:       want[i] = ($urandom_range(99) < 75);
                default: want[i] = 1'b0;
            endcase
        end
        full = (mode == 2) && ($urandom_range(3) == 0);
        r    = want;
        rst       = rst_next;
        req       = r;
        fifo_full = full;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = cur[i];

        exp_busy = m_busy;
        exp_gnt  = m_owner;
        wr = m_busy && r[2'(m_owner)] && !full;
        if (wr) begin
            exp_q.push_back('{id: m_owner, data: cur[m_owner], cyc: cyc});
            cur[m_owner] = DW'($urandom);
            m_writes++;
        end

        if (rst) begin
            m_busy = 1'b0; m_owner = N - 1; m_writes = 0;
        end else if (!m_busy) begin
            if (r != 0) begin
                m_busy = 1'b1; m_owner = next_owner(r, m_owner); m_writes = 0;
            end
        end else if (r[2'(m_owner)] && full) begin
            // stalled on a full fifo: grant unchanged
        end else if (!r[2'(m_owner)] || m_writes == MB) begin
            if (r != 0) begin
                m_owner = next_owner(r, m_owner); m_writes = 0;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_edge) begin
                chk(!fifo_wr && ack == 0 && !busy, "reset_outputs", {fifo_wr, busy, ack}, 0);
                chk(gnt_id == 2'(N - 1), "reset_gnt", int'(gnt_id), N - 1);
            end
            chk(busy == exp_busy, "busy", busy, exp_busy);
            if (busy) chk(int'(gnt_id) == exp_gnt, "gnt_id", int'(gnt_id), exp_gnt);
            if (fifo_wr) begin
                chk(!fifo_full, "wr_while_full", fifo_full, 0);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_write", int'(fifo_data), -1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk(e.cyc == cyc, "write_cycle", cyc, e.cyc);
                    chk(ack == (N'(1) << e.id), "ack", int'(ack), 1 << e.id);
                    chk(fifo_data == e.data, "fifo_data", int'(fifo_data), int'(e.data));
                end
            end else begin
                chk(ack == 0, "ack_no_write", int'(ack), 0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    chk(1'b0, "missed_write", exp_q[0].cyc, cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic run(input int m, input bit r, input int n);
        mode     = m;
        rst_next = r;
        repeat (n) drive_cycle();
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0; want = '0;
        for (int i = 0; i < N; i++) cur[i] = DW'($urandom);
        for (int k = 0; k < 6; k++) cur[1] = 8'hA0;
        run(1, 1'b1, 3);    // reset with all requesters active
        run(0, 1'b0, 12);   // sole requester: back-to-back re-grants
        run(1, 1'b0, 30);   // all requesting: 4-word bursts in rotation
        run(1, 1'b1, 3);    // reset mid-burst
        run(1, 1'b0, 20);
        run(2, 1'b0, 9000); // random requests, drops and full
        run(3, 1'b0, 10);   // idle drain
        @(negedge clk);
        #1;
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
